// File: rtl/led_scanner.sv
// led_scanner: N-wide LED bar animator with a built-in prescaler.
// Four modes (bounce, rotate-left, rotate-right, fill-bounce) advance one
// step per prescaler tick. All outputs come straight from registers.
module led_scanner #(
    parameter  int N_LEDS    = 8,
    parameter  int DIV_WIDTH = 24,
    localparam int POS_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 ENABLE,
    input  logic [1:0]           MODE,
    input  logic [DIV_WIDTH-1:0] SPEED,
    output logic [N_LEDS-1:0]    LEDG,
    output logic [POS_W-1:0]     POS,
    output logic                 STEP
);

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    localparam logic [POS_W-1:0]  POS_MAX    = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]  POS_MAX_M1 = POS_W'(N_LEDS - 2);
    localparam logic [POS_W-1:0]  POS_ONE    = POS_W'(1);
    localparam logic [N_LEDS-1:0] LEDG_ONE   = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LEDG_ALL   = {N_LEDS{1'b1}};
    localparam logic [N_LEDS-1:0] LEDG_RST   = LEDG_ONE << (N_LEDS - 1);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [POS_W-1:0]     r_pos;
    dir_t                 r_dir;
    logic [N_LEDS-1:0]    r_ledg;
    logic                 r_step;

    mode_t                w_mode;
    logic                 w_tick;
    logic [POS_W-1:0]     w_pos_nxt;
    dir_t                 w_dir_nxt;
    logic [N_LEDS-1:0]    w_ledg_nxt;

    assign w_mode = mode_t'(MODE);

    // >= compare so that lowering SPEED below the current count ticks at once
    assign w_tick = ENABLE && (r_cnt >= SPEED);

    // Next head position, direction and pattern for the coming step
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir;
        w_ledg_nxt = r_ledg;

        unique case (w_mode)
            MODE_ROT_L: begin
                w_dir_nxt = DIR_UP;
                w_pos_nxt = (r_pos == POS_MAX) ? '0 : r_pos + POS_ONE;
            end
            MODE_ROT_R: begin
                w_dir_nxt = DIR_DOWN;
                w_pos_nxt = (r_pos == '0) ? POS_MAX : r_pos - POS_ONE;
            end
            default: begin
                // Bounce and fill-bounce share the same head movement;
                // each endpoint is visited for one step only.
                if (r_dir == DIR_DOWN) begin
                    if (r_pos == '0) begin
                        w_dir_nxt = DIR_UP;
                        w_pos_nxt = POS_ONE;
                    end else begin
                        w_pos_nxt = r_pos - POS_ONE;
                    end
                end else begin
                    if (r_pos == POS_MAX) begin
                        w_dir_nxt = DIR_DOWN;
                        w_pos_nxt = POS_MAX_M1;
                    end else begin
                        w_pos_nxt = r_pos + POS_ONE;
                    end
                end
            end
        endcase

        // An out-of-range head (only reachable for non power-of-two widths)
        // is pulled back to the top LED.
        if (r_pos > POS_MAX) begin
            w_pos_nxt = POS_MAX;
        end

        if (w_mode == MODE_FILL) begin
            w_ledg_nxt = LEDG_ALL << w_pos_nxt;
        end else begin
            w_ledg_nxt = LEDG_ONE << w_pos_nxt;
        end
    end

    // Prescaler, animation state and step pulse
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt  <= '0;
            r_pos  <= POS_MAX;
            r_dir  <= DIR_DOWN;
            r_ledg <= LEDG_RST;
            r_step <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking so every register sees pre-edge values.
            r_step <= w_tick;
            if (ENABLE) begin
                r_cnt <= w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
            end
            if (w_tick) begin
                r_pos  <= w_pos_nxt;
                r_dir  <= w_dir_nxt;
                r_ledg <= w_ledg_nxt;
            end
        end
    end

    assign LEDG = r_ledg;
    assign POS  = r_pos;
    assign STEP = r_step;

endmodule
